// File: rtl/reg_pipeline.sv
// reg_pipeline: WIDTH-bit, DEPTH-stage retiming pipeline with valid/ready on
// both sides. Stalls propagate backwards through a combinational ready chain.
// Empty stages keep filling while later stages are stalled, so gaps between
// words close up. Flush discards all held words. count tracks how many stages
// hold a valid word.
module reg_pipeline #(
  parameter int unsigned      WIDTH       = 8,
  parameter int unsigned      DEPTH       = 3,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [WIDTH-1:0]           in_data,
  input  logic                       in_valid,
  output logic                       in_ready,
  output logic [WIDTH-1:0]           out_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  input  logic                       flush,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int unsigned CW = $clog2(DEPTH + 1);

  // Per-stage state. Index DEPTH-1 is the output stage.
  logic [WIDTH-1:0] data_q   [DEPTH];
  logic [DEPTH-1:0] valid_q;
  logic [CW-1:0]    count_q;

  // ready[i] means stage i can take a word this cycle.
  // ready[DEPTH] stands for the downstream side.
  logic [DEPTH:0]   ready;

  // load[i] means a word moves into stage i at the next edge.
  // src_data[i] is the word that moves in.
  logic [DEPTH-1:0] load;
  logic [WIDTH-1:0] src_data [DEPTH];

  logic accept;
  logic consume;

  // Ready chain, evaluated from the output stage back towards the input.
  // NOTE: every variable written in an always_comb is given a value before any
  // branch or loop, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    logic rdy;
    rdy          = out_ready;
    ready        = '0;
    ready[DEPTH] = out_ready;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      rdy      = ~valid_q[i] | rdy;
      ready[i] = rdy;
    end
  end

  assign in_ready = ready[0] & ~flush;
  assign accept   = in_valid & in_ready;
  assign consume  = valid_q[DEPTH-1] & out_ready;

  // Stage 0 is fed from the upstream port.
  // Every other stage is fed from the stage behind it.
  assign load[0]     = accept;
  assign src_data[0] = in_data;

  for (genvar g = 1; g < DEPTH; g++) begin : g_src
    assign load[g]     = valid_q[g-1] & ready[g];
    assign src_data[g] = data_q[g-1];
  end

  // Stage registers: load on transfer in, clear when the word leaves and none
  // arrives, hold when stalled. Flush clears valid bits but not data.
  // NOTE: data registers normally need no reset. They are reset here only
  // because out_data must show RESET_VALUE after reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      // NOTE: sequential state uses non-blocking assignments, so every stage
      // samples its neighbour's pre-edge value and the shift is order-independent.
      valid_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        data_q[i] <= RESET_VALUE;
      end
    end else if (flush) begin
      valid_q <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        valid_q[i] <= load[i] | (valid_q[i] & ~ready[i+1]);
        if (load[i]) begin
          data_q[i] <= src_data[i];
        end
      end
    end
  end

  // Occupancy: +1 per accepted word, -1 per consumed word, 0 on reset or flush.
  always_ff @(posedge clk) begin
    if (!reset || flush) begin
      count_q <= '0;
    end else begin
      count_q <= count_q + CW'(accept) - CW'(consume);
    end
  end

  assign out_data  = data_q[DEPTH-1];
  assign out_valid = valid_q[DEPTH-1];
  assign count     = count_q;

endmodule

// File: tb/tb_reg_pipeline.sv
// Testbench for reg_pipeline (WIDTH=8, DEPTH=3).
// The reference model is an ordered queue of words. Each word records the
// stage it occupies. The bench checks the DUT against the model every cycle,
// and pins the model with hand-computed literal expectations.
module tb_reg_pipeline;

  localparam int WIDTH = 8;
  localparam int DEPTH = 3;
  localparam int CW    = $clog2(DEPTH + 1);

  logic             clk = 1'b0;
  logic             reset;
  logic [WIDTH-1:0] in_data;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] out_data;
  logic             out_valid;
  logic             out_ready;
  logic             flush;
  logic [CW-1:0]    count;

  int n_cmp = 0;
  int n_bad = 0;
  bit started = 1'b0;

  // Model: words in arrival order (index 0 = oldest). pos is the stage index.
  typedef struct {
    logic [WIDTH-1:0] data;
    int               pos;
  } word_t;

  word_t mq[$];

  always #5 clk = ~clk;

  reg_pipeline #(
    .WIDTH      (WIDTH),
    .DEPTH      (DEPTH),
    .RESET_VALUE(8'h00)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .in_data  (in_data),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .out_data (out_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .flush    (flush),
    .count    (count)
  );

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, got, exp);
    end
  endtask

  // Each word moves one stage forward unless the word ahead of it stays put
  // directly in front. The oldest word's limit is the downstream side, which
  // it reaches only when out_ready is high. A computed position of DEPTH
  // means the word leaves.
  function automatic void m_plan(input bit ord, output int np[DEPTH]);
    int hi;
    hi = DEPTH + (ord ? 1 : 0);
    for (int k = 0; k < DEPTH; k++) np[k] = 0;
    for (int k = 0; k < mq.size(); k++) begin
      np[k] = (mq[k].pos + 1 < hi - 1) ? mq[k].pos + 1 : hi - 1;
      hi    = np[k];
    end
  endfunction

  // The upstream side is ready when stage 0 is free after this cycle's moves.
  function automatic bit m_in_ready();
    int np[DEPTH];
    if (flush) return 1'b0;
    m_plan(out_ready, np);
    return (mq.size() == 0) || (np[mq.size()-1] > 0);
  endfunction

  function automatic bit m_out_valid();
    return (mq.size() > 0) && (mq[0].pos == DEPTH - 1);
  endfunction

  // Model update at every rising edge.
  always @(posedge clk) begin
    int    np[DEPTH];
    bit    acc;
    word_t w;
    if (!reset || flush) begin
      mq.delete();
    end else begin
      acc = in_valid && m_in_ready();
      m_plan(out_ready, np);
      for (int k = 0; k < mq.size(); k++) mq[k].pos = np[k];
      if (mq.size() > 0 && mq[0].pos == DEPTH) void'(mq.pop_front());
      if (acc) begin
        w.data = in_data;
        w.pos  = 0;
        mq.push_back(w);
      end
    end
    started = 1'b1;
  end

  // Compare DUT against the model mid-cycle, after the inputs have settled.
  always @(negedge clk) begin
    #2;
    if (started) begin
      check("m_count", 32'(count), 32'(mq.size()));
      check("m_out_valid", 32'(out_valid), 32'(m_out_valid()));
      if (m_out_valid()) check("m_out_data", 32'(out_data), 32'(mq[0].data));
      check("m_in_ready", 32'(in_ready), 32'(m_in_ready()));
    end
  end

  // Drive one cycle's inputs on the falling edge, then settle for local checks.
  task automatic cyc(input bit v, input logic [7:0] d, input bit ordy, input bit fl, input bit rst);
    @(negedge clk);
    in_valid  = v;
    in_data   = d;
    out_ready = ordy;
    flush     = fl;
    reset     = rst;
    #3;
  endtask

  task automatic chk_out(input string name, input bit v, input logic [7:0] d, input int c);
    check({name, "_valid"}, 32'(out_valid), 32'(v));
    if (v) check({name, "_data"}, 32'(out_data), 32'(d));
    check({name, "_count"}, 32'(count), 32'(c));
    check({name, "_model_count"}, 32'(mq.size()), 32'(c));
  endtask

  initial begin
    reset     = 1'b0;
    in_valid  = 1'b1;
    in_data   = 8'hAE;
    out_ready = 1'b1;
    flush     = 1'b0;

    // Reset held with a word offered: nothing is taken.
    cyc(1, 8'hAE, 1, 0, 0);
    chk_out("rst1", 0, 8'h00, 0);
    check("rst1_out_data", 32'(out_data), 32'h00);
    cyc(0, 8'h00, 1, 0, 1);
    chk_out("rst2", 0, 8'h00, 0);
    check("rst2_out_data", 32'(out_data), 32'h00);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    for (int n = 0; n < 4; n++) begin
      cyc(0, 8'h00, 1, 0, 1);
      chk_out("rst_idle", 0, 8'h00, 0);
    end

    // Streaming with out_ready held high.
    cyc(1, 8'hAE, 1, 0, 1);
    cyc(1, 8'h77, 1, 0, 1); chk_out("st_k",   0, 8'h00, 1);
    cyc(1, 8'h12, 1, 0, 1); chk_out("st_k1",  0, 8'h00, 2);
    cyc(0, 8'h00, 1, 0, 1); chk_out("st_k2",  1, 8'hAE, 3);
    cyc(0, 8'h00, 1, 0, 1); chk_out("st_k3",  1, 8'h77, 2);
    cyc(0, 8'h00, 1, 0, 1); chk_out("st_k4",  1, 8'h12, 1);
    cyc(0, 8'h00, 1, 0, 1); chk_out("st_k5",  0, 8'h00, 0);

    // Backpressure fill, then drain.
    cyc(1, 8'h01, 0, 0, 1);
    cyc(1, 8'h02, 0, 0, 1);
    cyc(1, 8'h03, 0, 0, 1);
    cyc(1, 8'h04, 0, 0, 1); chk_out("bp_full", 1, 8'h01, 3);
    check("bp_in_ready", 32'(in_ready), 32'd0);
    cyc(1, 8'h04, 0, 0, 1); chk_out("bp_hold", 1, 8'h01, 3);
    check("bp_in_ready2", 32'(in_ready), 32'd0);
    cyc(1, 8'h04, 1, 0, 1);
    check("bp_full_ready", 32'(in_ready), 32'd1);
    cyc(0, 8'h00, 1, 0, 1); chk_out("bp_d2", 1, 8'h02, 3);
    cyc(0, 8'h00, 1, 0, 1); chk_out("bp_d3", 1, 8'h03, 2);
    cyc(0, 8'h00, 1, 0, 1); chk_out("bp_d4", 1, 8'h04, 1);
    cyc(0, 8'h00, 1, 0, 1); chk_out("bp_empty", 0, 8'h00, 0);

    // Gaps between words close up while the output is stalled.
    cyc(1, 8'hA1, 0, 0, 1);
    cyc(0, 8'h00, 0, 0, 1);
    cyc(1, 8'hA2, 0, 0, 1);
    cyc(0, 8'h00, 0, 0, 1);
    cyc(0, 8'h00, 1, 0, 1); chk_out("bub_packed", 1, 8'hA1, 2);
    cyc(0, 8'h00, 1, 0, 1); chk_out("bub_a2", 1, 8'hA2, 1);
    cyc(0, 8'h00, 1, 0, 1); chk_out("bub_empty", 0, 8'h00, 0);

    // Flush mid-stream with a word offered: the word is not taken.
    cyc(1, 8'hB1, 0, 0, 1);
    cyc(1, 8'hB2, 0, 0, 1);
    cyc(1, 8'h55, 0, 1, 1); chk_out("fl_before", 0, 8'h00, 2);
    check("fl_in_ready", 32'(in_ready), 32'd0);
    cyc(0, 8'h00, 0, 0, 1); chk_out("fl_after", 0, 8'h00, 0);
    for (int n = 0; n < 4; n++) begin
      cyc(0, 8'h00, 1, 0, 1);
      chk_out("fl_drain", 0, 8'h00, 0);
    end

    // Full pipeline: accept and consume in the same cycle.
    cyc(1, 8'hD1, 0, 0, 1);
    cyc(1, 8'hD2, 0, 0, 1);
    cyc(1, 8'hD3, 0, 0, 1);
    cyc(1, 8'hC3, 1, 0, 1); chk_out("sim_full", 1, 8'hD1, 3);
    check("sim_in_ready", 32'(in_ready), 32'd1);
    cyc(0, 8'h00, 1, 0, 1); chk_out("sim_k",  1, 8'hD2, 3);
    cyc(0, 8'h00, 1, 0, 1); chk_out("sim_k1", 1, 8'hD3, 2);
    cyc(0, 8'h00, 1, 0, 1); chk_out("sim_k2", 1, 8'hC3, 1);
    cyc(0, 8'h00, 1, 0, 1); chk_out("sim_end", 0, 8'h00, 0);

    // Random traffic. Blocks alternate between mostly-stalled and
    // mostly-flowing output so both full and sparse pipelines are exercised.
    for (int n = 0; n < 3000; n++) begin
      bit ordy;
      ordy = ((n % 200) < 100) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
      cyc($urandom_range(0, 2) != 0, 8'($urandom), ordy,
          $urandom_range(0, 39) == 0, $urandom_range(0, 149) != 0);
    end

    for (int n = 0; n < 6; n++) cyc(0, 8'h00, 1, 0, 1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/reg_pipeline.md
# reg_pipeline

Parametrised multi-stage pipeline register with a valid/ready handshake on both sides. It generalises the team's fixed 8-bit register to WIDTH bits and DEPTH stages, and adds per-stage valid tracking, backpressure with bubble collapse, a synchronous flush and an occupancy count. It is used wherever a datapath needs retiming stages that can stall without dropping or duplicating words.

## Interface
- WIDTH, 8: data width in bits; must be ≥1.
- DEPTH, 3: number of register stages; must be ≥1.
- RESET_VALUE, '0: value loaded into every stage's data register on reset.
- clk  input  1  rising-edge clock; the only clock.
- reset  input  1  synchronous, active-low reset, sampled on rising clk.
- in_data  input  WIDTH  upstream word.
- in_valid  input  1  upstream word present.
- in_ready  output  1  block accepts in_data this cycle.
- out_data  output  WIDTH  data register of the last stage (DEPTH-1).
- out_valid  output  1  valid bit of the last stage.
- out_ready  input  1  downstream accepts out_data this cycle.
- flush  input  1  synchronous discard of all held words.
- count  output  $clog2(DEPTH+1)  number of stages holding a valid word.

## Operation
- Each stage i holds data_i[WIDTH-1:0] and valid_i.
- The last stage is ready when out_ready=1. Stage i is ready when ~valid_i | ready_(i+1), with stage DEPTH standing for the downstream side.
- in_ready = ready_0 & ~flush. This is a combinational path from out_ready through the chain and is intentional.
- Transfer rules:
  - An input is accepted when in_valid & in_ready.
  - An output is consumed when out_valid & out_ready.
  - A transfer from stage i to i+1 happens when valid_i & ready_(i+1).
- On a transfer into a stage, that stage loads data and sets valid. A stage that loses its word and receives none clears valid.
- A stalled stage holds its data and valid bit unchanged. A bubble (invalid stage) is filled even while later stages stall, so that bubbles collapse.
- Data registers of invalid stages may hold stale values. out_data is meaningful only when out_valid=1.
- flush=1 at a rising edge clears all valid bits and sets count to 0. Data registers are untouched. in_ready=0 during flush, so no input is taken. A word presented with out_valid & out_ready in the flush cycle counts as consumed.
- count equals the popcount of the valid bits and is registered. Its next value is count + accept − consume, and 0 on flush or reset.
- Word order is strictly preserved. No word is dropped except by flush or reset, and none is duplicated.

## Timing
- Reset (reset=0 at an edge), registered outputs after that edge: all valid=0, out_valid=0, count=0, out_data=RESET_VALUE.
- in_ready during reset follows the combinational rule: 1 when flush=0, since the stages are empty. Inputs are ignored while reset=0.
- Reset takes priority over flush. Flush takes priority over all transfers.
- Latency with no stall: a word accepted at edge k appears with out_valid=1 after edge k+DEPTH−1, i.e. DEPTH cycles from in_valid to out_valid.
- Throughput is one word per cycle when out_ready=1 continuously.
- Full: count=DEPTH and out_ready=0 give in_ready=0. If count=DEPTH and out_ready=1, then in_ready=1, and the simultaneous accept and consume leave count unchanged.
- Empty: out_valid=0 regardless of out_ready. count never underflows.
- Reset asserted mid-stream discards all words in one edge. The first accept after reset deasserts behaves as from empty.

## Test plan
- Reset: hold reset=0 for 2 cycles with in_valid=1, in_data=8'hAE, then release. Required: out_valid=0, count=0 and out_data=8'h00 throughout; no word emerges afterwards.
- Streaming, WIDTH=8, DEPTH=3, out_ready=1: push 8'hAE, 8'h77, 8'h12 on consecutive edges k, k+1, k+2. Required: out_valid is high after edges k+2, k+3, k+4 with exactly those values in order; count peaks at 3.
- Backpressure fill: with out_ready=0, offer 8'h01..8'h04 continuously. Required: 8'h01..8'h03 are accepted and in_ready drops to 0; count=3; out_data=8'h01 is held stable. Then raise out_ready. Required: 8'h01..8'h04 emerge in order, one per cycle.
- Bubble collapse: send 8'hA1, idle one cycle, send 8'hA2 with out_ready=0. Required: both words pack into stages 2 and 1 and count=2. On releasing out_ready, the words emerge on consecutive cycles.
- Flush mid-stream: with count=2 and out_ready=0, pulse flush for one cycle while in_valid=1, in_data=8'h55. Required: in_ready=0 that cycle; next cycle count=0 and out_valid=0; 8'h55 never appears.
- Simultaneous full accept/consume: with count=3 and out_ready=1, push 8'hC3. Required: in_ready=1, count stays 3, the head word leaves, and 8'hC3 emerges three cycles later.
